// File: rtl/binary_mul_pipe_n.sv
// binary_mul_pipe_n
//   Pipelined WIDTH x WIDTH carry-save array multiplier with a per-operation
//   unsigned / two's-complement select (Baugh-Wooley correction gated by tc).
//   The array rows (half-adder row, full-adder rows, ripple merge row) are
//   divided over STAGES register stages. The last register stage is the
//   product register P. It loads only when a valid operation reaches it, so
//   P holds its value through bubbles.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears all stages, P, out_valid)
//   en         global advance; 0 freezes every register
//   in_valid   A/B/tc carry a new operation (sampled when en=1)
//   tc         0: unsigned operands, 1: two's-complement operands
//   A, B       WIDTH-bit multiplicand / multiplier
//   out_valid  P holds a newly completed product
//   P          2*WIDTH-bit product register
module binary_mul_pipe_n #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic                 tc,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   P
);

  localparam int unsigned PW = 2 * WIDTH;

  // One pipeline slot. Finished low product bits live in the low end of the
  // sum vector. B bits already folded into the array are never read again
  // downstream.
  typedef struct packed {
    logic [PW-1:0]    s;
    logic [PW-1:0]    c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             tc;
    logic             v;
  } stage_t;

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];

  // Last array row (1..WIDTH) evaluated in stage k. Rows left over after an
  // even split go to the earliest stages, which keeps the merge row (row
  // WIDTH) in the last stage.
  function automatic int unsigned stage_last(input int unsigned k);
    int unsigned extra;
    extra = ((k + 1) < (WIDTH % STAGES)) ? (k + 1) : (WIDTH % STAGES);
    return (k + 1) * (WIDTH / STAGES) + extra;
  endfunction

  function automatic int unsigned stage_first(input int unsigned k);
    return (k == 0) ? 1 : stage_last(k - 1) + 1;
  endfunction

  // Partial-product row j placed at column offset j. In signed mode, bits
  // that involve exactly one operand MSB are inverted (Baugh-Wooley).
  function automatic logic [PW-1:0] pp_row(input logic [WIDTH-1:0] a,
                                           input logic b_j,
                                           input logic t,
                                           input int unsigned j);
    logic [PW-1:0] row;
    row = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      row[i + j] = (a[i] & b_j) ^ (t & ((i == WIDTH - 1) != (j == WIDTH - 1)));
    end
    return row;
  endfunction

  // Row 1: half-adder row (carry vector is still empty).
  // Rows 2..WIDTH-1: full-adder rows folding in partial product row r.
  // Row WIDTH: ripple vector-merge of sum and carry.
  function automatic stage_t apply_row(input stage_t st, input int unsigned r);
    stage_t        nx;
    logic [PW-1:0] pp;
    logic          cy;
    nx = st;
    if (r == WIDTH) begin
      cy = 1'b0;
      for (int unsigned i = 0; i < PW; i++) begin
        nx.s[i] = st.s[i] ^ st.c[i] ^ cy;
        cy      = (st.s[i] & st.c[i]) | (st.s[i] & cy) | (st.c[i] & cy);
      end
      nx.c = '0;
    end else begin
      pp = pp_row(st.a, st.b[r], st.tc, r);
      if (r == 1) begin
        nx.s = st.s ^ pp;
        nx.c = (st.s & pp) << 1;
      end else begin
        nx.s = st.s ^ st.c ^ pp;
        nx.c = ((st.s & st.c) | (st.s & pp) | (st.c & pp)) << 1;
      end
    end
    return nx;
  endfunction

  always_comb begin
    stage_t        cur;
    logic [PW-1:0] bw_const;

    stage_d = stage_q;

    // Row 0 carries the Baugh-Wooley constants: columns WIDTH and PW-1 are
    // outside the span of partial-product row 0, so they ride along for free.
    bw_const         = '0;
    bw_const[WIDTH]  = tc;
    bw_const[PW-1]   = tc;
    cur              = '0;
    cur.s            = pp_row(A, B[0], tc, 0) | bw_const;
    cur.a            = A;
    cur.b            = B;
    cur.tc           = tc;
    cur.v            = in_valid;

    for (int unsigned k = 0; k < STAGES; k++) begin
      if (k != 0) begin
        cur = stage_q[k - 1];
      end
      for (int unsigned r = 1; r <= WIDTH; r++) begin
        if ((r >= stage_first(k)) && (r <= stage_last(k))) begin
          cur = apply_row(cur, r);
        end
      end
      if (k < STAGES - 1) begin
        stage_d[k] = cur;
      end else begin
        // Output slot: only the product and its valid bit matter; the
        // product is held unless a valid result arrives.
        stage_d[k]   = '0;
        stage_d[k].v = cur.v;
        stage_d[k].s = cur.v ? cur.s : stage_q[k].s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '{default: '0};
    end else if (en) begin
      stage_q <= stage_d;
    end
  end

  assign P         = stage_q[STAGES - 1].s;
  assign out_valid = stage_q[STAGES - 1].v;

endmodule
